// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter in front of a small register file.
// After reset it clears every register once (INIT), then forwards at most one
// write per cycle from two requesters using round-robin arbitration (RUN).
//
// Handshake: a requester raises valid together with index/data and holds all
// three stable until it sees ready. A transfer happens on the rising edge where
// valid and ready are both 1; ready is combinational, so the regfile write and
// the acceptance land on the same edge. Nothing is buffered here.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic [INDEX_WIDTH-1:0] req0_index,
  input  logic [DATA_WIDTH-1:0]  req0_data,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [INDEX_WIDTH-1:0] req1_index,
  input  logic [DATA_WIDTH-1:0]  req1_data,
  output logic                   req1_ready,
  output logic                   rf_write_enable,
  output logic [INDEX_WIDTH-1:0] rf_write_index,
  output logic [DATA_WIDTH-1:0]  rf_write_data,
  output logic                   init_done,
  output logic [7:0]             conflict_count,
  output logic                   o_dbg_state
);

  localparam int NUM_REGS = 2 ** INDEX_WIDTH;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  logic [INDEX_WIDTH-1:0] r_clear_ptr;
  logic                   r_last_grant;   // 1: requester 1 was granted last
  logic                   r_init_done;
  logic [7:0]             r_conflict_count;

  logic w_run;
  logic w_grant0;
  logic w_grant1;
  logic w_both_valid;

  // Round-robin grant: a lone requester always wins; on contention the one
  // not granted last wins. Reset gates everything off combinationally.
  always_comb begin
    w_run        = (r_state == ST_RUN) && !reset;
    w_both_valid = req0_valid && req1_valid;
    w_grant0     = w_run && req0_valid && (!req1_valid || r_last_grant);
    w_grant1     = w_run && req1_valid && (!req0_valid || !r_last_grant);
  end

  assign req0_ready     = w_grant0;
  assign req1_ready     = w_grant1;
  assign init_done      = r_init_done;
  assign conflict_count = r_conflict_count;
  assign o_dbg_state    = r_state;

  // Regfile write port: clear pattern in INIT, granted requester's fields in RUN.
  always_comb begin
    rf_write_enable = 1'b0;
    rf_write_index  = '0;
    rf_write_data   = '0;
    if (!reset) begin
      if (r_state == ST_INIT) begin
        rf_write_enable = 1'b1;
        rf_write_index  = r_clear_ptr;
      end else if (w_grant0) begin
        rf_write_enable = 1'b1;
        rf_write_index  = req0_index;
        rf_write_data   = req0_data;
      end else if (w_grant1) begin
        rf_write_enable = 1'b1;
        rf_write_index  = req1_index;
        rf_write_data   = req1_data;
      end
    end
  end

  // Controller FSM: clear sweep, then arbitration bookkeeping and conflict count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_INIT;
      r_clear_ptr      <= '0;
      r_last_grant     <= 1'b1;
      r_init_done      <= 1'b0;
      r_conflict_count <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clear_ptr <= r_clear_ptr + INDEX_WIDTH'(1);
          if (r_clear_ptr == LAST_IDX) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_grant0) begin
            r_last_grant <= 1'b0;
          end else if (w_grant1) begin
            r_last_grant <= 1'b1;
          end
          if (w_both_valid && (r_conflict_count != 8'hFF)) begin
            r_conflict_count <= r_conflict_count + 8'd1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule
